// File: rtl/satd_hadamard4x4_pkg.sv
// satd_pkg: shared widths, FSM state encoding and a row-slice helper for the
// 4x4 Hadamard SATD block.
//   DIFF_W : signed residual width per sample
//   ROW_W  : width after the row (first) Hadamard pass
//   COEF_W : width after the column (second) Hadamard pass
//   SATD_W : width of the accumulated, unsigned block SATD
package satd_pkg;

  localparam int DIFF_W = 9;
  localparam int ROW_W  = DIFF_W + 2;
  localparam int COEF_W = DIFF_W + 4;
  localparam int SATD_W = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    COLS = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sample j of a packed residual row lives at [DIFF_W*j +: DIFF_W].
  function automatic logic [DIFF_W-1:0] row_sample(input logic [4*DIFF_W-1:0] row,
                                                   input logic [1:0]          j);
    return row[DIFF_W*int'(j) +: DIFF_W];
  endfunction

endpackage

// File: rtl/satd_hadamard4x4_if.sv
// satd_hadamard4x4_if: row input and SATD output handshakes of the block.
//   in_valid/in_ready/in_row    : one packed 4-sample residual row per transfer
//   out_valid/out_ready/out_satd: block SATD toward the cost logic
// master = producer/consumer side (testbench), slave = satd_hadamard4x4.
interface satd_hadamard4x4_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [4*satd_pkg::DIFF_W-1:0]     in_row;
  logic                              out_valid;
  logic                              out_ready;
  logic [satd_pkg::SATD_W-1:0]       out_satd;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_satd
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_satd
  );

endinterface

// File: rtl/satd_hadamard4x4_hadamard4.sv
// hadamard4: combinational 4-point Hadamard butterfly.
//   x0..x3 : signed inputs, IN_W bits
//   h0..h3 : signed outputs, IN_W+2 bits (two butterfly stages, never wraps)
module hadamard4 #(
  parameter int IN_W = 9
) (
  input  logic signed [IN_W-1:0] x0,
  input  logic signed [IN_W-1:0] x1,
  input  logic signed [IN_W-1:0] x2,
  input  logic signed [IN_W-1:0] x3,
  output logic signed [IN_W+1:0] h0,
  output logic signed [IN_W+1:0] h1,
  output logic signed [IN_W+1:0] h2,
  output logic signed [IN_W+1:0] h3
);

  logic signed [IN_W+1:0] e0, e1, e2, e3;
  logic signed [IN_W+1:0] s01, d01, s23, d23;

  always_comb begin
    e0  = (IN_W+2)'(x0);
    e1  = (IN_W+2)'(x1);
    e2  = (IN_W+2)'(x2);
    e3  = (IN_W+2)'(x3);
    s01 = e0 + e1;
    d01 = e0 - e1;
    s23 = e2 + e3;
    d23 = e2 - e3;
    h0  = s01 + s23;
    h1  = d01 + d23;
    h2  = s01 - s23;
    h3  = d01 - d23;
  end

endmodule

// File: rtl/satd_hadamard4x4.sv
// satd_hadamard4x4: 4x4 Hadamard SATD of one residual block.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort of the partial block and pending result
//   bus        : satd_hadamard4x4_if.slave (row input, SATD output)
// Rows are row-transformed on arrival into a 4x4 buffer; the four columns are
// then transformed one per cycle and their absolute coefficients accumulated.
// Optional macro SATD_NORM_EN: output (sum + 1) >> 1 instead of the raw sum.
module satd_hadamard4x4
  import satd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  satd_hadamard4x4_if.slave   bus
);

  state_e                   state_q, state_d;
  logic [1:0]               r_cnt_q, r_cnt_d;
  logic [1:0]               c_cnt_q, c_cnt_d;
  logic [SATD_W-1:0]        acc_q, acc_d;
  logic [SATD_W-1:0]        out_satd_q, out_satd_d;
  logic signed [ROW_W-1:0]  row_buf_q [4][4];
  logic signed [ROW_W-1:0]  row_buf_d [4][4];

  logic signed [ROW_W-1:0]  row_h [4];
  logic signed [COEF_W-1:0] col_h [4];
  logic [COEF_W-1:0]        col_abs [4];
  logic [SATD_W-1:0]        col_sum;
  logic [SATD_W-1:0]        total;
  logic [SATD_W-1:0]        final_satd;

  hadamard4 #(.IN_W(DIFF_W)) u_row_pass (
    .x0(signed'(row_sample(bus.in_row, 2'd0))),
    .x1(signed'(row_sample(bus.in_row, 2'd1))),
    .x2(signed'(row_sample(bus.in_row, 2'd2))),
    .x3(signed'(row_sample(bus.in_row, 2'd3))),
    .h0(row_h[0]), .h1(row_h[1]), .h2(row_h[2]), .h3(row_h[3])
  );

  hadamard4 #(.IN_W(ROW_W)) u_col_pass (
    .x0(row_buf_q[0][c_cnt_q]),
    .x1(row_buf_q[1][c_cnt_q]),
    .x2(row_buf_q[2][c_cnt_q]),
    .x3(row_buf_q[3][c_cnt_q]),
    .h0(col_h[0]), .h1(col_h[1]), .h2(col_h[2]), .h3(col_h[3])
  );

  // Magnitudes keep the full coefficient width so that the most negative
  // coefficient still yields an exact unsigned value.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      col_abs[i] = col_h[i][COEF_W-1] ? COEF_W'(-col_h[i]) : COEF_W'(col_h[i]);
    end
    col_sum = SATD_W'(col_abs[0]) + SATD_W'(col_abs[1]) +
              SATD_W'(col_abs[2]) + SATD_W'(col_abs[3]);
    total   = acc_q + col_sum;
`ifdef SATD_NORM_EN
    final_satd = SATD_W'(({1'b0, total} + (SATD_W+1)'(1)) >> 1);
`else
    final_satd = total;
`endif
  end

  // Next-state logic; flush is applied last so it overrides any handshake.
  always_comb begin
    state_d    = state_q;
    r_cnt_d    = r_cnt_q;
    c_cnt_d    = c_cnt_q;
    acc_d      = acc_q;
    out_satd_d = out_satd_q;
    row_buf_d  = row_buf_q;

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          for (int j = 0; j < 4; j++) row_buf_d[r_cnt_q][j] = row_h[j];
          r_cnt_d = r_cnt_q + 2'd1;
          if (r_cnt_q == 2'd3) begin
            state_d = COLS;
            c_cnt_d = 2'd0;
            acc_d   = '0;
          end
        end
      end
      COLS: begin
        acc_d   = total;
        c_cnt_d = c_cnt_q + 2'd1;
        if (c_cnt_q == 2'd3) begin
          out_satd_d = final_satd;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          r_cnt_d = 2'd0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    if (flush) begin
      state_d = LOAD;
      r_cnt_d = 2'd0;
      c_cnt_d = 2'd0;
      acc_d   = '0;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      r_cnt_q    <= 2'd0;
      c_cnt_q    <= 2'd0;
      acc_q      <= '0;
      out_satd_q <= '0;
    end else begin
      state_q    <= state_d;
      r_cnt_q    <= r_cnt_d;
      c_cnt_q    <= c_cnt_d;
      acc_q      <= acc_d;
      out_satd_q <= out_satd_d;
    end
  end

  // Transpose buffer needs no reset: it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    row_buf_q <= row_buf_d;
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_satd  = out_satd_q;

endmodule

// File: tb/tb_satd_hadamard4x4.sv
// tb_satd_hadamard4x4: directed self-checking bench for satd_hadamard4x4.
// Expected SATD values are hand-computed raw sums, normalised by the bench
// when SATD_NORM_EN is defined.
module tb_satd_hadamard4x4;
  import satd_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  satd_hadamard4x4_if bus();

  satd_hadamard4x4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [4*DIFF_W-1:0] packRow(input int a, input int b,
                                                  input int c, input int d);
    logic [DIFF_W-1:0] s0, s1, s2, s3;
    s0 = a[DIFF_W-1:0];
    s1 = b[DIFF_W-1:0];
    s2 = c[DIFF_W-1:0];
    s3 = d[DIFF_W-1:0];
    return {s3, s2, s1, s0};
  endfunction

  function automatic int expSatd(input int raw);
`ifdef SATD_NORM_EN
    return (raw + 1) >> 1;
`else
    return raw;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offer one row for exactly one clock edge; sampling resumes 1 ns later.
  task automatic applyStimulus(input logic [4*DIFF_W-1:0] row);
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendBlock(input logic [4*DIFF_W-1:0] r0, input logic [4*DIFF_W-1:0] r1,
                           input logic [4*DIFF_W-1:0] r2, input logic [4*DIFF_W-1:0] r3);
    applyStimulus(r0);
    applyStimulus(r1);
    applyStimulus(r2);
    applyStimulus(r3);
  endtask

  // Count edges after row 3 until out_valid (bounded), then check the value.
  task automatic waitResult(input string tag, input int raw);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, n, 4);
    checkOutput({tag, "_satd"}, bus.out_satd, expSatd(raw));
  endtask

  // With out_ready high, DONE lasts one cycle and LOAD follows.
  task automatic checkRelease(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, bus.out_valid, 0);
    checkOutput({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4*DIFF_W-1:0] zr;
    logic [4*DIFF_W-1:0] p1234;
    logic [4*DIFF_W-1:0] p255;
    logic [4*DIFF_W-1:0] chkA;
    logic [4*DIFF_W-1:0] chkB;
    int                  staleCount;

    zr    = '0;
    p1234 = packRow(1, 2, 3, 4);
    p255  = packRow(255, 0, 0, 0);
    chkA  = packRow(255, -255, 255, -255);
    chkB  = packRow(-255, 255, -255, 255);

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b1;

    #23;
    $display("[TB] reset state");
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_satd", bus.out_satd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] all-zero block");
    sendBlock(zr, zr, zr, zr);
    checkOutput("zero_busy", bus.in_ready, 0);
    waitResult("zero", 0);
    checkRelease("zero");

    $display("[TB] row0 = 1,2,3,4");
    sendBlock(p1234, zr, zr, zr);
    waitResult("r1234", 64);
    checkRelease("r1234");

    $display("[TB] single sample 255");
    sendBlock(p255, zr, zr, zr);
    waitResult("single", 4080);
    checkRelease("single");

    $display("[TB] checkerboard 255");
    sendBlock(chkA, chkB, chkA, chkB);
    waitResult("checker", 4080);
    checkOutput("checker_no_ovf", (bus.out_satd < 16'd65280), 1);
    checkRelease("checker");

    $display("[TB] back-pressure hold");
    bus.out_ready = 1'b0;
    sendBlock(p1234, zr, zr, zr);
    waitResult("hold", 64);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_satd", bus.out_satd, expSatd(64));
      checkOutput("hold_valid", bus.out_valid, 1);
      checkOutput("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("hold_accept_valid", bus.out_valid, 0);
    checkOutput("hold_accept_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    sendBlock(p255, zr, zr, zr);
    waitResult("after_hold", 4080);
    checkRelease("after_hold");

    $display("[TB] reset during column pass");
    sendBlock(p1234, p255, zr, zr);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    checkOutput("midrst_out_satd", bus.out_satd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    staleCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) staleCount++;
    end
    checkOutput("midrst_no_result", staleCount, 0);
    checkOutput("midrst_ready_after", bus.in_ready, 1);

    $display("[TB] flush after two rows");
    applyStimulus(p255);
    applyStimulus(p255);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_row   = packRow(100, 0, 0, 0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_in_ready", bus.in_ready, 1);
    checkOutput("flush_out_valid", bus.out_valid, 0);
    sendBlock(zr, zr, zr, zr);
    waitResult("flush", 0);
    checkRelease("flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
